hls_deadlock_reporter: RTL and testbench

- Receiver side of the dataflow deadlock-monitor `block` flag.
- Qualifies the flag over a programmable persistence window and snapshots the per-process idle, channel-block and axis-block vectors at qualification. It also timestamps the event and counts events.
- Delivers one report record per deadlock episode over a valid/ready interface to the debug/status logic at the top of the dataflow region.
- Re-arms only after the flag deasserts.

---
 rtl/hls_deadlock_pkg.sv | 39 +++
 rtl/hls_deadlock_persist_cnt.sv | 52 +++++
 rtl/hls_deadlock_reporter.sv | 142 ++++++++++++++
 tb/tb_hls_deadlock_reporter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hls_deadlock_pkg.sv
// rtl/hls_deadlock_pkg.sv - shared types and constants for the deadlock reporter
//
// Purpose: state encoding, event-counter sizing, arm-counter sizing and the
// report-record layout (default configuration) shared by the reporter and
// its consumers at the top of the dataflow region.
// Ports: none (package).
package hls_deadlock_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    REPORT = 2'd2,
    HOLD   = 2'd3
  } dl_state_e;

  localparam int EVT_CNT_W = 8;
  localparam logic [EVT_CNT_W-1:0] EVT_CNT_MAX = 8'd255;

  // Wide enough for THRESHOLD-1 with THRESHOLD up to 255.
  localparam int ARM_CNT_W = 8;

  localparam int DEF_NPROC = 5;
  localparam int DEF_NAXIS = 3;
  localparam int DEF_CYC_W = 32;

  // Report record for the default configuration.
  typedef struct packed {
    logic [DEF_NPROC-1:0] idle_vec;
    logic [DEF_NPROC-1:0] block_vec;
    logic [DEF_NAXIS-1:0] axis_vec;
    logic [DEF_CYC_W-1:0] cycle;
  } rpt_rec_t;

  // Event counter increment that sticks at its maximum.
  function automatic logic [EVT_CNT_W-1:0] evt_sat_inc(input logic [EVT_CNT_W-1:0] v);
    return (v == EVT_CNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/hls_deadlock_persist_cnt.sv
// rtl/hls_deadlock_persist_cnt.sv - persistence qualifier for the deadlock flag
//
// Purpose: counts consecutive cycles of block_i while enable_i is high and
// emits a one-cycle qualify_o in the cycle where the run reaches THRESHOLD.
// The count clears whenever block_i is low, when disabled, and on qualify.
// Ports:
//   clock, reset  system clock, synchronous active-high reset
//   enable_i      counting allowed (reporter is in IDLE or ARM)
//   block_i       deadlock flag from the monitor
//   qualify_o     flag has persisted THRESHOLD cycles (capture this cycle)
import hls_deadlock_pkg::*;

module hls_deadlock_persist_cnt #(
  parameter int THRESHOLD = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic enable_i,
  input  logic block_i,
  output logic qualify_o
);

  if (THRESHOLD < 1 || THRESHOLD > 255) begin : g_bad_threshold
    $error("hls_deadlock_persist_cnt: THRESHOLD must be in 1..255");
  end

  localparam logic [ARM_CNT_W-1:0] ARM_LAST = ARM_CNT_W'(THRESHOLD - 1);

  logic [ARM_CNT_W-1:0] arm_cnt_q;
  logic [ARM_CNT_W-1:0] arm_cnt_d;

  always_comb begin
    qualify_o = 1'b0;
    arm_cnt_d = '0;
    if (enable_i && block_i) begin
      if (arm_cnt_q == ARM_LAST) begin
        qualify_o = 1'b1;
      end else begin
        arm_cnt_d = arm_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      arm_cnt_q <= '0;
    end else begin
      arm_cnt_q <= arm_cnt_d;
    end
  end

endmodule

// File: rtl/hls_deadlock_reporter.sv
// rtl/hls_deadlock_reporter.sv - qualifies the dataflow deadlock flag and reports it
//
// Purpose: qualifies block_in over THRESHOLD cycles, snapshots the process
// idle/block and axis-block vectors with a cycle timestamp, and hands one
// record per deadlock episode to the consumer over valid/ready. Keeps a
// sticky deadlock flag and a saturating event counter.
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   block_in              registered deadlock flag
//   inst_idle_sigs        per-process idle           (NPROC)
//   inst_block_sigs       per-process channel block  (NPROC)
//   axis_block_sigs       per-stream axis block      (NAXIS)
//   clear                 clears deadlock_sticky and event_count
//   rpt_valid/rpt_ready   report handshake
//   rpt_idle_vec, rpt_block_vec, rpt_axis_vec, rpt_cycle  captured record
//   deadlock_sticky       set on any capture
//   event_count           captures, saturating at 255
import hls_deadlock_pkg::*;

module hls_deadlock_reporter #(
  parameter int NPROC     = 5,
  parameter int NAXIS     = 3,
  parameter int THRESHOLD = 4,
  parameter int CYC_W     = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 block_in,
  input  logic [NPROC-1:0]     inst_idle_sigs,
  input  logic [NPROC-1:0]     inst_block_sigs,
  input  logic [NAXIS-1:0]     axis_block_sigs,
  input  logic                 clear,
  output logic                 rpt_valid,
  input  logic                 rpt_ready,
  output logic [NPROC-1:0]     rpt_idle_vec,
  output logic [NPROC-1:0]     rpt_block_vec,
  output logic [NAXIS-1:0]     rpt_axis_vec,
  output logic [CYC_W-1:0]     rpt_cycle,
  output logic                 deadlock_sticky,
  output logic [EVT_CNT_W-1:0] event_count
);

  // Record sized for this instance's parameters.
  typedef struct packed {
    logic [NPROC-1:0] idle_vec;
    logic [NPROC-1:0] block_vec;
    logic [NAXIS-1:0] axis_vec;
    logic [CYC_W-1:0] cycle;
  } rec_t;

  dl_state_e            state_q, state_d;
  logic [CYC_W-1:0]     cyc_cnt_q;
  rec_t                 rec_q, rec_d;
  logic                 sticky_q, sticky_d;
  logic [EVT_CNT_W-1:0] evt_q, evt_d;

  logic armable;
  logic capture;

  assign armable = (state_q == IDLE) || (state_q == ARM);

  hls_deadlock_persist_cnt #(
    .THRESHOLD (THRESHOLD)
  ) u_persist (
    .clock     (clock),
    .reset     (reset),
    .enable_i  (armable),
    .block_i   (block_in),
    .qualify_o (capture)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ARM: begin
        if (capture) begin
          state_d = REPORT;
        end else if (block_in) begin
          state_d = ARM;
        end else begin
          state_d = IDLE;
        end
      end
      REPORT: begin
        // A drop of block_in here does not retract the report; it only
        // decides whether we must wait for the episode to end afterwards.
        if (rpt_ready) begin
          state_d = block_in ? HOLD : IDLE;
        end
      end
      HOLD: begin
        if (!block_in) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rec_d    = rec_q;
    sticky_d = sticky_q;
    evt_d    = evt_q;
    if (capture) begin
      rec_d.idle_vec  = inst_idle_sigs;
      rec_d.block_vec = inst_block_sigs;
      rec_d.axis_vec  = axis_block_sigs;
      rec_d.cycle     = cyc_cnt_q;
      sticky_d        = 1'b1;
      // A coincident clear restarts the count at this capture.
      evt_d           = clear ? EVT_CNT_W'(1) : evt_sat_inc(evt_q);
    end else if (clear) begin
      sticky_d = 1'b0;
      evt_d    = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cyc_cnt_q <= '0;
      rec_q     <= '0;
      sticky_q  <= 1'b0;
      evt_q     <= '0;
    end else begin
      state_q   <= state_d;
      cyc_cnt_q <= cyc_cnt_q + CYC_W'(1);
      rec_q     <= rec_d;
      sticky_q  <= sticky_d;
      evt_q     <= evt_d;
    end
  end

  assign rpt_valid       = (state_q == REPORT);
  assign rpt_idle_vec    = rec_q.idle_vec;
  assign rpt_block_vec   = rec_q.block_vec;
  assign rpt_axis_vec    = rec_q.axis_vec;
  assign rpt_cycle       = rec_q.cycle;
  assign deadlock_sticky = sticky_q;
  assign event_count     = evt_q;

endmodule

// File: tb/tb_hls_deadlock_reporter.sv
// tb/tb_hls_deadlock_reporter.sv - self-checking bench for hls_deadlock_reporter
module tb_hls_deadlock_reporter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic block_in = 1'b0, clear = 1'b0, rpt_ready = 1'b0;
  logic b1_block = 1'b0, b1_clear = 1'b0, b1_ready = 1'b0;
  logic [4:0] inst_idle_sigs = '0, inst_block_sigs = '0;
  logic [2:0] axis_block_sigs = '0;

  logic        rpt_valid, deadlock_sticky;
  logic [4:0]  rpt_idle_vec, rpt_block_vec;
  logic [2:0]  rpt_axis_vec;
  logic [31:0] rpt_cycle;
  logic [7:0]  event_count;

  logic        v1, sticky1;
  logic [4:0]  idle1, blk1;
  logic [2:0]  axis1;
  logic [3:0]  cyc1;
  logic [7:0]  cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  hls_deadlock_reporter #(.NPROC(5), .NAXIS(3), .THRESHOLD(4), .CYC_W(32)) dut (
    .clock(clock), .reset(reset), .block_in(block_in),
    .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs),
    .axis_block_sigs(axis_block_sigs), .clear(clear),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
    .rpt_idle_vec(rpt_idle_vec), .rpt_block_vec(rpt_block_vec),
    .rpt_axis_vec(rpt_axis_vec), .rpt_cycle(rpt_cycle),
    .deadlock_sticky(deadlock_sticky), .event_count(event_count)
  );

  // Second instance: single-cycle threshold and a short counter to see wrap.
  hls_deadlock_reporter #(.NPROC(5), .NAXIS(3), .THRESHOLD(1), .CYC_W(4)) dut1 (
    .clock(clock), .reset(reset), .block_in(b1_block),
    .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs),
    .axis_block_sigs(axis_block_sigs), .clear(b1_clear),
    .rpt_valid(v1), .rpt_ready(b1_ready),
    .rpt_idle_vec(idle1), .rpt_block_vec(blk1),
    .rpt_axis_vec(axis1), .rpt_cycle(cyc1),
    .deadlock_sticky(sticky1), .event_count(cnt1)
  );

  // Reference model: length of the current high run, whether a report is
  // outstanding, and whether the current episode has already been reported.
  int          m_th[2] = '{4, 1};
  logic [31:0] m_mask[2] = '{32'hFFFF_FFFF, 32'h0000_000F};
  int          m_run[2];
  bit          m_pend[2], m_done[2], m_sticky[2];
  int          m_cnt[2];
  logic [4:0]  m_idle[2], m_blk[2];
  logic [2:0]  m_axis[2];
  logic [31:0] m_cycv[2], m_cyc[2];

  task automatic model_step(input int k, input bit rst, input bit blk, input bit rdy, input bit clr);
    bit cap;
    if (rst) begin
      m_run[k] = 0; m_pend[k] = 0; m_done[k] = 0; m_sticky[k] = 0; m_cnt[k] = 0;
      m_idle[k] = '0; m_blk[k] = '0; m_axis[k] = '0; m_cycv[k] = '0; m_cyc[k] = '0;
      return;
    end
    cap = 0;
    if (m_pend[k]) begin
      if (rdy) begin
        m_pend[k] = 0;
        m_done[k] = blk;
      end
    end else if (m_done[k]) begin
      if (!blk) m_done[k] = 0;
    end else if (blk) begin
      m_run[k] = m_run[k] + 1;
      if (m_run[k] == m_th[k]) begin
        cap = 1; m_run[k] = 0; m_pend[k] = 1;
      end
    end else begin
      m_run[k] = 0;
    end
    if (cap) begin
      m_idle[k] = inst_idle_sigs; m_blk[k] = inst_block_sigs; m_axis[k] = axis_block_sigs;
      m_cycv[k] = m_cyc[k];
      m_sticky[k] = 1;
      m_cnt[k] = clr ? 1 : ((m_cnt[k] < 255) ? m_cnt[k] + 1 : 255);
    end else if (clr) begin
      m_sticky[k] = 0; m_cnt[k] = 0;
    end
    m_cyc[k] = (m_cyc[k] + 32'd1) & m_mask[k];
  endtask

  task automatic tick();
    model_step(0, reset, block_in, rpt_ready, clear);
    model_step(1, reset, b1_block, b1_ready, b1_clear);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; block_in = 0; clear = 0; rpt_ready = 0;
    b1_block = 0; b1_clear = 0; b1_ready = 0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    do_reset();
    checks++; if (rpt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", rpt_valid); end
    checks++; if (deadlock_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky got=%0b exp=0", deadlock_sticky); end
    checks++; if (event_count !== 8'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", event_count); end
    checks++; if (rpt_cycle !== 32'd0) begin errors++; $display("FAIL reset_cycle got=%0d exp=0", rpt_cycle); end
    checks++; if ({rpt_idle_vec, rpt_block_vec, rpt_axis_vec} !== 13'd0) begin errors++; $display("FAIL reset_payload got=%h exp=0", {rpt_idle_vec, rpt_block_vec, rpt_axis_vec}); end
    checks++; if ({v1, sticky1, cnt1} !== 10'd0) begin errors++; $display("FAIL reset_dut1 got=%h exp=0", {v1, sticky1, cnt1}); end
  endtask

  task automatic test_glitch();
    do_reset();
    rpt_ready = 1;
    for (int i = 0; i < 10; i++) begin
      block_in = (i < 3);
      inst_idle_sigs = 5'($urandom);
      tick();
      checks++; if (rpt_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid cyc=%0d got=%0b exp=0", i, rpt_valid); end
    end
    checks++; if (deadlock_sticky !== 1'b0) begin errors++; $display("FAIL glitch_sticky got=%0b exp=0", deadlock_sticky); end
    checks++; if (event_count !== 8'd0) begin errors++; $display("FAIL glitch_count got=%0d exp=0", event_count); end
  endtask

  task automatic test_basic();
    int seen;
    do_reset();
    rpt_ready = 1;
    inst_idle_sigs = 5'b10110; inst_block_sigs = 5'b01001; axis_block_sigs = 3'b010;
    for (int i = 0; i < 20 && m_cyc[0] != 10; i++) tick();
    block_in = 1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (rpt_valid !== (m_cyc[0] == 32'd14)) begin errors++; $display("FAIL basic_valid cyc=%0d got=%0b exp=%0b", m_cyc[0], rpt_valid, m_cyc[0] == 32'd14); end
      if (rpt_valid) seen++;
    end
    checks++; if (seen != 1) begin errors++; $display("FAIL basic_valid_cycles got=%0d exp=1", seen); end
    checks++; if (rpt_idle_vec !== 5'b10110) begin errors++; $display("FAIL basic_idle got=%b exp=10110", rpt_idle_vec); end
    checks++; if (rpt_block_vec !== 5'b01001) begin errors++; $display("FAIL basic_block got=%b exp=01001", rpt_block_vec); end
    checks++; if (rpt_axis_vec !== 3'b010) begin errors++; $display("FAIL basic_axis got=%b exp=010", rpt_axis_vec); end
    checks++; if (rpt_cycle !== 32'd13) begin errors++; $display("FAIL basic_cycle got=%0d exp=13", rpt_cycle); end
    checks++; if (event_count !== 8'd1) begin errors++; $display("FAIL basic_count got=%0d exp=1", event_count); end
    checks++; if (deadlock_sticky !== 1'b1) begin errors++; $display("FAIL basic_sticky got=%0b exp=1", deadlock_sticky); end
    block_in = 0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [12:0] pay;
    logic [31:0] pcyc;
    do_reset();
    tick();
    inst_idle_sigs = 5'($urandom); inst_block_sigs = 5'($urandom); axis_block_sigs = 3'($urandom);
    pay = {inst_idle_sigs, inst_block_sigs, axis_block_sigs};
    pcyc = m_cyc[0] + 32'd3;
    block_in = 1;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (rpt_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_start got=%0b exp=1", rpt_valid); end
    for (int i = 0; i < 6; i++) begin
      inst_idle_sigs = ~inst_idle_sigs; inst_block_sigs = 5'($urandom); axis_block_sigs = ~axis_block_sigs;
      block_in = (i != 2);
      tick();
      checks++; if (rpt_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_hold i=%0d got=%0b exp=1", i, rpt_valid); end
      checks++; if ({rpt_idle_vec, rpt_block_vec, rpt_axis_vec} !== pay) begin errors++; $display("FAIL bp_payload i=%0d got=%h exp=%h", i, {rpt_idle_vec, rpt_block_vec, rpt_axis_vec}, pay); end
      checks++; if (rpt_cycle !== pcyc) begin errors++; $display("FAIL bp_cycle i=%0d got=%0d exp=%0d", i, rpt_cycle, pcyc); end
    end
    block_in = 1; rpt_ready = 1;
    tick();
    checks++; if (rpt_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_drop got=%0b exp=0", rpt_valid); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (rpt_valid !== 1'b0) begin errors++; $display("FAIL bp_hold_no_rpt i=%0d got=%0b exp=0", i, rpt_valid); end
    end
    block_in = 0;
    tick();
    block_in = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (rpt_valid !== 1'b0) begin errors++; $display("FAIL bp_rearm_early i=%0d got=%0b exp=0", i, rpt_valid); end
    end
    tick();
    checks++; if (rpt_valid !== 1'b1) begin errors++; $display("FAIL bp_rearm_valid got=%0b exp=1", rpt_valid); end
    checks++; if (event_count !== 8'd2) begin errors++; $display("FAIL bp_count got=%0d exp=2", event_count); end
    block_in = 0;
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    rpt_ready = 1;
    for (int ep = 0; ep < 256; ep++) begin
      block_in = 1;
      for (int i = 0; i < 4; i++) tick();
      block_in = 0;
      tick();
      checks++; if (event_count !== 8'(m_cnt[0])) begin errors++; $display("FAIL sat_count_model ep=%0d got=%0d exp=%0d", ep, event_count, m_cnt[0]); end
      if (ep >= 254) begin
        checks++; if (event_count !== 8'd255) begin errors++; $display("FAIL sat_count ep=%0d got=%0d exp=255", ep, event_count); end
      end
    end
    clear = 1;
    tick();
    clear = 0;
    checks++; if (event_count !== 8'd0) begin errors++; $display("FAIL clear_count got=%0d exp=0", event_count); end
    checks++; if (deadlock_sticky !== 1'b0) begin errors++; $display("FAIL clear_sticky got=%0b exp=0", deadlock_sticky); end
    block_in = 1;
    for (int i = 0; i < 4; i++) tick();
    block_in = 0;
    tick();
    block_in = 1;
    for (int i = 0; i < 3; i++) tick();
    clear = 1;
    tick();
    clear = 0;
    checks++; if (event_count !== 8'd1) begin errors++; $display("FAIL clear_vs_capture_count got=%0d exp=1", event_count); end
    checks++; if (deadlock_sticky !== 1'b1) begin errors++; $display("FAIL clear_vs_capture_sticky got=%0b exp=1", deadlock_sticky); end
    checks++; if (rpt_valid !== 1'b1) begin errors++; $display("FAIL clear_vs_capture_valid got=%0b exp=1", rpt_valid); end
    block_in = 0;
    tick();
  endtask

  task automatic test_thresh1_wrap();
    logic [3:0] exp_c;
    do_reset();
    b1_ready = 1;
    tick(); tick();
    inst_idle_sigs = 5'($urandom);
    exp_c = m_cyc[1][3:0];
    b1_block = 1;
    tick();
    b1_block = 0;
    checks++; if (v1 !== 1'b1) begin errors++; $display("FAIL th1_valid got=%0b exp=1", v1); end
    checks++; if (cyc1 !== exp_c) begin errors++; $display("FAIL th1_cycle got=%0d exp=%0d", cyc1, exp_c); end
    checks++; if (idle1 !== m_idle[1]) begin errors++; $display("FAIL th1_idle got=%b exp=%b", idle1, m_idle[1]); end
    tick();
    checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL th1_valid_drop got=%0b exp=0", v1); end
    for (int i = 0; i < 20 && m_cyc[1] != 32'd15; i++) tick();
    b1_block = 1;
    tick();
    b1_block = 0;
    checks++; if (cyc1 !== 4'hF) begin errors++; $display("FAIL th1_cycle_top got=%0d exp=15", cyc1); end
    tick();
    for (int i = 0; i < 20 && m_cyc[1] != 32'd0; i++) tick();
    b1_block = 1;
    tick();
    b1_block = 0;
    checks++; if (cyc1 !== 4'h0) begin errors++; $display("FAIL th1_cycle_wrap got=%0d exp=0", cyc1); end
    checks++; if (cnt1 !== 8'd3) begin errors++; $display("FAIL th1_count got=%0d exp=3", cnt1); end
    tick();
  endtask

  task automatic test_reset_in_report();
    do_reset();
    rpt_ready = 0;
    inst_idle_sigs = 5'h1F; inst_block_sigs = 5'h15; axis_block_sigs = 3'h7;
    block_in = 1;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (rpt_valid !== 1'b1) begin errors++; $display("FAIL rstrpt_pre_valid got=%0b exp=1", rpt_valid); end
    reset = 1;
    tick();
    checks++; if (rpt_valid !== 1'b0) begin errors++; $display("FAIL rstrpt_valid got=%0b exp=0", rpt_valid); end
    checks++; if ({rpt_idle_vec, rpt_block_vec, rpt_axis_vec, rpt_cycle, deadlock_sticky, event_count} !== 54'd0) begin errors++; $display("FAIL rstrpt_outputs got=%h exp=0", {rpt_idle_vec, rpt_block_vec, rpt_axis_vec, rpt_cycle, deadlock_sticky, event_count}); end
    reset = 0; block_in = 0;
    tick();
  endtask

  task automatic test_random();
    int run_left, run_left1;
    do_reset();
    run_left = 0; run_left1 = 0;
    for (int i = 0; i < 800; i++) begin
      if (run_left == 0) begin
        block_in = $urandom_range(0, 1);
        run_left = $urandom_range(1, 9);
      end
      run_left--;
      if (run_left1 == 0) begin
        b1_block = $urandom_range(0, 1);
        run_left1 = $urandom_range(1, 4);
      end
      run_left1--;
      rpt_ready = ($urandom_range(0, 2) != 0);
      b1_ready = $urandom_range(0, 1);
      clear = ($urandom_range(0, 24) == 0);
      b1_clear = ($urandom_range(0, 24) == 0);
      inst_idle_sigs = 5'($urandom); inst_block_sigs = 5'($urandom); axis_block_sigs = 3'($urandom);
      tick();
      checks++; if (rpt_valid !== m_pend[0]) begin errors++; $display("FAIL rnd_valid i=%0d got=%0b exp=%0b", i, rpt_valid, m_pend[0]); end
      checks++; if ({rpt_idle_vec, rpt_block_vec, rpt_axis_vec, rpt_cycle} !== {m_idle[0], m_blk[0], m_axis[0], m_cycv[0]}) begin errors++; $display("FAIL rnd_payload i=%0d got=%h exp=%h", i, {rpt_idle_vec, rpt_block_vec, rpt_axis_vec, rpt_cycle}, {m_idle[0], m_blk[0], m_axis[0], m_cycv[0]}); end
      checks++; if ({deadlock_sticky, event_count} !== {m_sticky[0], 8'(m_cnt[0])}) begin errors++; $display("FAIL rnd_status i=%0d got=%h exp=%h", i, {deadlock_sticky, event_count}, {m_sticky[0], 8'(m_cnt[0])}); end
      checks++; if ({v1, idle1, blk1, axis1, cyc1, sticky1, cnt1} !== {m_pend[1], m_idle[1], m_blk[1], m_axis[1], m_cycv[1][3:0], m_sticky[1], 8'(m_cnt[1])}) begin errors++; $display("FAIL rnd_dut1 i=%0d got=%h exp=%h", i, {v1, idle1, blk1, axis1, cyc1, sticky1, cnt1}, {m_pend[1], m_idle[1], m_blk[1], m_axis[1], m_cycv[1][3:0], m_sticky[1], 8'(m_cnt[1])}); end
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_basic();
    test_backpressure();
    test_saturation();
    test_thresh1_wrap();
    test_reset_in_report();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
